cipher_stream_ctrl: RTL

CIPHER_STREAM_CTRL -- requirements
Module: cipher_stream_ctrl

---
 rtl/cipher_stream_ctrl_pkg.sv | 28 ++
 rtl/cipher_stream_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cipher_stream_ctrl_pkg.sv
// Shared types and constants for the cipher stream controller: FSM states,
// load-code encoding and the key/IV word slicing helper.
package cipher_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_IV,
    WARMUP,
    READY,
    SHIFT,
    HOLD
  } state_t;

  localparam int         WARMUP_CYCLES_DEFAULT = 1152;
  localparam logic [2:0] LD_NONE               = 3'd0;
  localparam int         LD_WORDS              = 3;

  // 80-bit key/IV presented to the engine as three 32-bit words, low word first.
  function automatic logic [31:0] ld_word(input logic [79:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[31:0];
      2'd1:    return v[63:32];
      default: return {16'h0000, v[79:64]};
    endcase
  endfunction

endpackage

// File: rtl/cipher_stream_ctrl.sv
// Byte-stream front end for a bit-serial stream cipher engine: loads key/IV,
// runs the warm-up clocks, then serialises plaintext bytes through the engine.
module cipher_stream_ctrl
  import cipher_stream_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  output logic        ready_o,
  input  logic [7:0]  s_dat_i,
  input  logic        s_vld_i,
  output logic        s_rdy_o,
  output logic [7:0]  m_dat_o,
  output logic        m_vld_o,
  input  logic        m_rdy_i,
  output logic        eng_ce_o,
  output logic [31:0] eng_ld_dat_o,
  output logic [2:0]  eng_ld_a_o,
  output logic [2:0]  eng_ld_b_o,
  output logic        eng_pt_bit_o,
  input  logic        eng_ct_bit_i
);

  localparam logic [10:0] WARM_LAST = 11'(WARMUP_CYCLES - 1);
  localparam logic [10:0] WORD_LAST = 11'(LD_WORDS - 1);

  state_t      state, state_nxt;
  logic [10:0] cnt;
  logic [79:0] key_q, iv_q;
  logic [7:0]  sh_q;
  logic [7:0]  m_dat_q;
  logic        m_vld_q;

  logic out_free, accept, shift_last, load_out, take_key;

  assign out_free   = !m_vld_q || m_rdy_i;
  assign accept     = (state == READY) && s_vld_i && !start_i;
  assign shift_last = (cnt[2:0] == 3'd7);
  assign load_out   = ((state == SHIFT && shift_last) || state == HOLD) && out_free;
  assign take_key   = start_i && (state == IDLE || state == READY);

  assign m_dat_o = m_dat_q;
  assign m_vld_o = m_vld_q;

  // NOTE: every output and state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt    = state;
    ready_o      = 1'b0;
    s_rdy_o      = 1'b0;
    eng_ce_o     = 1'b0;
    eng_ld_dat_o = 32'h0;
    eng_ld_a_o   = LD_NONE;
    eng_ld_b_o   = LD_NONE;
    eng_pt_bit_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = LOAD_KEY;
      LOAD_KEY: begin
        eng_ld_a_o   = 3'(cnt[1:0]) + 3'd1;
        eng_ld_dat_o = ld_word(key_q, cnt[1:0]);
        if (cnt == WORD_LAST) state_nxt = LOAD_IV;
      end
      LOAD_IV: begin
        eng_ld_b_o   = 3'(cnt[1:0]) + 3'd1;
        eng_ld_dat_o = ld_word(iv_q, cnt[1:0]);
        if (cnt == WORD_LAST) state_nxt = WARMUP;
      end
      WARMUP: begin
        eng_ce_o = 1'b1;
        if (cnt == WARM_LAST) state_nxt = READY;
      end
      READY: begin
        ready_o = 1'b1;
        s_rdy_o = !start_i;
        // A restart request outranks a waiting byte.
        if (start_i)      state_nxt = LOAD_KEY;
        else if (s_vld_i) state_nxt = SHIFT;
      end
      SHIFT: begin
        eng_ce_o     = 1'b1;
        eng_pt_bit_o = sh_q[0];
        if (shift_last) state_nxt = out_free ? READY : HOLD;
      end
      HOLD:    if (out_free) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // One counter serves word index, warm-up length and bit index; it restarts on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_nxt != state) begin
      cnt <= '0;
    end else if (state == LOAD_KEY || state == LOAD_IV || state == WARMUP || state == SHIFT) begin
      cnt <= cnt + 11'd1;
    end
  end

  // NOTE: key/IV holding registers are left unreset; they are only observed after a start_i reloads them.
  always_ff @(posedge clk_i) begin
    if (take_key) begin
      key_q <= key_i;
      iv_q  <= iv_i;
    end
  end

  // Plaintext leaves from bit 0 while ciphertext enters at bit 7, so after
  // eight shifts the register holds the ciphertext byte in natural order.
  always_ff @(posedge clk_i) begin
    if (rst_i)               sh_q <= 8'h00;
    else if (accept)         sh_q <= s_dat_i;
    else if (state == SHIFT) sh_q <= {eng_ct_bit_i, sh_q[7:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_vld_q <= 1'b0;
      m_dat_q <= 8'h00;
    end else if (load_out) begin
      m_vld_q <= 1'b1;
      m_dat_q <= (state == SHIFT) ? {eng_ct_bit_i, sh_q[7:1]} : sh_q;
    end else if (m_rdy_i) begin
      m_vld_q <= 1'b0;
    end
  end

endmodule
